pbkdf2_job_dispatcher: RTL and testbench

//  Hardware-side driver for the PBKDF2 core (i_start/i_pw/i_salt -> o_key/o_ready).

---
 rtl/pbkdf2_job_dispatcher.sv | 128 ++++++++++++
 tb/tb_pbkdf2_job_dispatcher.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pbkdf2_job_dispatcher.sv
// Drives one PBKDF2 core per job: core reset, start pulse, wait for the ready edge, return key/match.
// Result appears 1 cycle after the core ready edge or timeout; o_res_* held until i_res_ready, no job accepted meanwhile.
module pbkdf2_job_dispatcher #(
    parameter int PW_W      = 1088,
    parameter int SALT_W    = 1088,
    parameter int KEY_W     = 256,
    parameter int RST_CYC   = 1,
    parameter int START_CYC = 2,
    parameter int TIMEOUT   = 2000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_job_valid,
    output logic              o_job_ready,
    input  logic [PW_W-1:0]   i_job_pw,
    input  logic [SALT_W-1:0] i_job_salt,
    input  logic [KEY_W-1:0]  i_job_expect,
    input  logic              i_job_check,
    output logic              o_core_rst_n,
    output logic              o_core_start,
    output logic [PW_W-1:0]   o_core_pw,
    output logic [SALT_W-1:0] o_core_salt,
    input  logic [KEY_W-1:0]  i_core_key,
    input  logic              i_core_ready,
    output logic              o_res_valid,
    input  logic              i_res_ready,
    output logic [KEY_W-1:0]  o_res_key,
    output logic              o_res_match,
    output logic              o_res_timeout,
    output logic [15:0]       o_err_cnt
);
    localparam int PH_W  = $clog2(RST_CYC + START_CYC + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, CRST, GAP, START, WAIT, RESULT} state_t;

    state_t             state, next_state;
    logic [PH_W-1:0]    ph_cnt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               ready_d;
    logic [KEY_W-1:0]   expect_q;
    logic               check_q;
    logic               done_edge, tmo_hit, accept, job_done, key_ok;

    assign done_edge = i_core_ready & ~ready_d;
    assign tmo_hit   = (tmo_cnt == TMO_W'(TIMEOUT - 1));
    assign accept    = i_job_valid & o_job_ready;
    assign job_done  = ((state == START) || (state == WAIT)) && (done_edge || tmo_hit);
    assign key_ok    = (i_core_key == expect_q);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (accept) next_state = CRST;
            CRST:   if (ph_cnt == PH_W'(RST_CYC - 1)) next_state = GAP;
            GAP:    next_state = START;
            // A completion edge or timeout cuts the start pulse short.
            START: begin
                if (done_edge || tmo_hit)                  next_state = RESULT;
                else if (ph_cnt == PH_W'(START_CYC - 1))   next_state = WAIT;
            end
            WAIT:   if (done_edge || tmo_hit) next_state = RESULT;
            RESULT: if (i_res_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // rst_n gates the core controls so the core stays in reset for the whole reset pulse.
    always_comb begin
        o_job_ready  = 1'b0;
        o_core_rst_n = rst_n;
        o_core_start = 1'b0;
        case (state)
            IDLE:    o_job_ready  = rst_n;
            CRST:    o_core_rst_n = 1'b0;
            START:   o_core_start = rst_n;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ph_cnt        <= '0;
            tmo_cnt       <= '0;
            ready_d       <= 1'b0;
            expect_q      <= '0;
            check_q       <= 1'b0;
            o_core_pw     <= '0;
            o_core_salt   <= '0;
            o_res_valid   <= 1'b0;
            o_res_key     <= '0;
            o_res_match   <= 1'b0;
            o_res_timeout <= 1'b0;
            o_err_cnt     <= '0;
        end else begin
            ready_d <= (state == CRST) ? 1'b0 : i_core_ready;
            ph_cnt  <= (next_state != state) ? '0 : ph_cnt + PH_W'(1);
            if (state == GAP)
                tmo_cnt <= '0;
            else if ((state == START) || (state == WAIT))
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (accept) begin
                o_core_pw   <= i_job_pw;
                o_core_salt <= i_job_salt;
                expect_q    <= i_job_expect;
                check_q     <= i_job_check;
            end
            if (job_done) begin
                o_res_valid   <= 1'b1;
                o_res_timeout <= ~done_edge;
                o_res_key     <= done_edge ? i_core_key : '0;
                o_res_match   <= done_edge & check_q & key_ok;
                if ((~done_edge | (check_q & ~key_ok)) && (o_err_cnt != 16'hFFFF))
                    o_err_cnt <= o_err_cnt + 16'd1;
            end else if ((state == RESULT) && i_res_ready) begin
                o_res_valid   <= 1'b0;
                o_res_key     <= '0;
                o_res_match   <= 1'b0;
                o_res_timeout <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pbkdf2_job_dispatcher.sv
// Randomized bench for pbkdf2_job_dispatcher with a job-level timing/result model and a core stand-in.
module tb_pbkdf2_job_dispatcher;
    localparam int PW_W = 1088, SALT_W = 1088, KEY_W = 256;
    localparam int RST_CYC = 1, START_CYC = 2, TIMEOUT = 2000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic i_job_valid = 1'b0, o_job_ready, i_job_check = 1'b0;
    logic [PW_W-1:0] i_job_pw = '0, o_core_pw;
    logic [SALT_W-1:0] i_job_salt = '0, o_core_salt;
    logic [KEY_W-1:0] i_job_expect = '0, i_core_key = '0, o_res_key;
    logic o_core_rst_n, o_core_start, i_core_ready = 1'b0;
    logic o_res_valid, i_res_ready = 1'b0, o_res_match, o_res_timeout;
    logic [15:0] o_err_cnt;

    pbkdf2_job_dispatcher #(.PW_W(PW_W), .SALT_W(SALT_W), .KEY_W(KEY_W), .RST_CYC(RST_CYC),
                            .START_CYC(START_CYC), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .i_job_valid(i_job_valid), .o_job_ready(o_job_ready),
        .i_job_pw(i_job_pw), .i_job_salt(i_job_salt), .i_job_expect(i_job_expect),
        .i_job_check(i_job_check), .o_core_rst_n(o_core_rst_n), .o_core_start(o_core_start),
        .o_core_pw(o_core_pw), .o_core_salt(o_core_salt), .i_core_key(i_core_key),
        .i_core_ready(i_core_ready), .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
        .o_res_key(o_res_key), .o_res_match(o_res_match), .o_res_timeout(o_res_timeout),
        .o_err_cnt(o_err_cnt));

    always #5 clk = ~clk;

    typedef struct {
        logic [PW_W-1:0]   pw;
        logic [SALT_W-1:0] salt;
        logic [KEY_W-1:0]  exp_key;
        logic              check;
        int                lat;       // cycles from first start cycle to core ready; -1 = never
        logic [KEY_W-1:0]  core_key;
    } job_t;

    int errors = 0, checks = 0, cyc = 0;
    job_t cur, act;

    // Job-level model state
    bit m_busy = 0, m_match, m_tmo, m_inc;
    int m_acc, m_s, m_edge, m_res;
    logic [KEY_W-1:0] m_key;
    logic [15:0] m_err = '0;
    logic [PW_W-1:0] m_pw = '0;
    logic [SALT_W-1:0] m_salt = '0;
    bit e_valid, e_rstn, e_start, acc, rst_prev = 0, res_prev = 0;
    logic [15:0] e_err;

    int mon_rst_low, mon_start, mon_first_start, mon_res_rise, acc_cyc, hs_cyc, n_results = 0;
    bit force_rdy = 0, model_rdy = 0, armed = 0, start_prev = 0;
    int rdy_at;

    logic [KEY_W-1:0] r_key;
    logic r_match, r_tmo;
    logic [15:0] r_err;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk1(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, got, want);
        end
    endfunction

    function automatic void chkk(input string name, input logic [KEY_W-1:0] got, input logic [KEY_W-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
        end
    endfunction

    function automatic void chki(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, want);
        end
    endfunction

    function automatic logic [PW_W-1:0] rnd_wide();
        logic [PW_W-1:0] r;
        for (int i = 0; i < PW_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic job_t mk(input logic check, input int lat, input bit corrupt);
        job_t j;
        logic [PW_W-1:0] w;
        j.pw = rnd_wide();
        j.salt = rnd_wide();
        w = rnd_wide();
        j.exp_key = w[KEY_W-1:0];
        j.core_key = corrupt ? (j.exp_key ^ 256'h1) : j.exp_key;
        j.check = check;
        j.lat = lat;
        return j;
    endfunction

    // Compare process: every cycle, DUT outputs against the job-level model.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk1("rst_core_rst_n", o_core_rst_n, 1'b0);
                chk1("rst_job_ready", o_job_ready, 1'b0);
                if (rst_prev) begin
                    chk1("rst_res_valid", o_res_valid, 1'b0);
                    chkk("rst_res_key", o_res_key, '0);
                    chk1("rst_res_match", o_res_match, 1'b0);
                    chk1("rst_res_timeout", o_res_timeout, 1'b0);
                    chkk("rst_err_cnt", KEY_W'(o_err_cnt), '0);
                    chk1("rst_core_start", o_core_start, 1'b0);
                    chk1("rst_core_pw_salt", (o_core_pw === '0) && (o_core_salt === '0), 1'b1);
                end
                m_busy = 0; m_err = '0; m_pw = '0; m_salt = '0;
                rst_prev = 1; res_prev = 0;
            end else begin
                rst_prev = 0;
                e_valid = m_busy && (cyc >= m_res);
                e_rstn  = !(m_busy && (cyc >= m_acc + 1) && (cyc <= m_acc + RST_CYC));
                e_start = m_busy && (cyc >= m_s) && (cyc <= m_s + START_CYC - 1) &&
                          ((m_edge < 0) || (cyc <= m_edge));
                e_err = m_err;
                if (e_valid && m_inc && (m_err != 16'hFFFF)) e_err = m_err + 16'd1;
                chk1("job_ready", o_job_ready, !m_busy);
                chk1("core_rst_n", o_core_rst_n, e_rstn);
                chk1("core_start", o_core_start, e_start);
                chk1("res_valid", o_res_valid, e_valid);
                if (e_valid) begin
                    chkk("res_key", o_res_key, m_key);
                    chk1("res_match", o_res_match, m_match);
                    chk1("res_timeout", o_res_timeout, m_tmo);
                end
                chkk("err_cnt", KEY_W'(o_err_cnt), KEY_W'(e_err));
                chk1("core_pw_salt", (o_core_pw === m_pw) && (o_core_salt === m_salt), 1'b1);

                if (!o_core_rst_n) mon_rst_low++;
                if (o_core_start) begin
                    mon_start++;
                    if (mon_first_start < 0) mon_first_start = cyc;
                end
                if (o_res_valid && !res_prev) mon_res_rise = cyc;
                res_prev = o_res_valid;

                acc = !m_busy && i_job_valid;
                if (e_valid && i_res_ready) begin
                    m_busy = 0; m_err = e_err; hs_cyc = cyc; n_results++;
                end
                if (acc) begin
                    act = cur;
                    m_busy = 1; m_acc = cyc; acc_cyc = cyc;
                    m_s = cyc + RST_CYC + 2;
                    if (cur.lat >= 0 && cur.lat < TIMEOUT) begin
                        m_edge = m_s + cur.lat; m_res = m_edge + 1; m_tmo = 0;
                        m_key = cur.core_key;
                        m_match = cur.check && (cur.core_key == cur.exp_key);
                    end else begin
                        m_edge = -1; m_res = m_s + TIMEOUT; m_tmo = 1;
                        m_key = '0; m_match = 0;
                    end
                    m_inc = m_tmo || (cur.check && !m_match);
                    m_pw = cur.pw; m_salt = cur.salt;
                    mon_rst_low = 0; mon_start = 0; mon_first_start = -1; mon_res_rise = -1;
                end
            end
        end
    end

    // Core stand-in: ready rises act.lat cycles after the first start cycle, cleared by core reset.
    initial begin
        forever begin
            @(negedge clk);
            if (!o_core_rst_n) begin
                model_rdy = 0; armed = 0;
            end else if (o_core_start && !start_prev && act.lat >= 0) begin
                armed = 1; rdy_at = cyc + act.lat;
            end
            if (armed && cyc >= rdy_at) begin
                model_rdy = 1; i_core_key = act.core_key;
            end
            start_prev = o_core_start;
            i_core_ready = model_rdy | force_rdy;
        end
    end

    task automatic present(input job_t j);
        cur = j;
        i_job_pw = j.pw; i_job_salt = j.salt; i_job_expect = j.exp_key; i_job_check = j.check;
        i_job_valid = 1'b1;
    endtask

    task automatic wait_accept();
        int n = 0;
        bit got = 0;
        while (!got && n < 4000) begin
            @(negedge clk);
            n++;
            if (o_job_ready && i_job_valid) got = 1;
        end
        if (!got) begin
            errors++; checks++;
            $display("FAIL accept_wait cyc=%0d got=no accept want=accept", cyc);
        end
        @(posedge clk); #1;
        i_job_valid = 1'b0;
    endtask

    // mode 0: raise ready after 'hold' valid cycles; mode 1: random ready
    task automatic collect(input int mode, input int hold);
        int n = 0, vc = 0;
        bit got = 0;
        while (!got && n < 6000) begin
            @(negedge clk);
            n++;
            if (o_res_valid) vc++;
            if (o_res_valid && i_res_ready) begin
                got = 1;
                r_key = o_res_key; r_match = o_res_match; r_tmo = o_res_timeout; r_err = o_err_cnt;
            end
            @(posedge clk); #1;
            if (got)            i_res_ready = 1'b0;
            else if (mode == 1) i_res_ready = ($urandom_range(0, 2) != 0);
            else                i_res_ready = (vc > hold);
        end
        i_res_ready = 1'b0;
        if (!got) begin
            errors++; checks++;
            $display("FAIL result_wait cyc=%0d got=no result want=result", cyc);
        end
    endtask

    task automatic run(input job_t j, input int mode, input int hold);
        @(posedge clk); #1;
        present(j);
        wait_accept();
        collect(mode, hold);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got=still running want=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        job_t j, ja, jb;
        int nres;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk1("t0_job_ready_after_reset", o_job_ready, 1'b1);

        // 1: matching key, 50-cycle core
        j = mk(1'b1, 50, 1'b0);
        run(j, 0, 0);
        chki("t1_rst_low_cycles", mon_rst_low, 1);
        chki("t1_start_cycles", mon_start, 2);
        chki("t1_latency", mon_res_rise - mon_first_start, 51);
        chkk("t1_key", r_key, j.exp_key);
        chk1("t1_match", r_match, 1'b1);
        chk1("t1_timeout", r_tmo, 1'b0);
        chki("t1_err", int'(r_err), 0);

        // 2: wrong key with and without check
        j = mk(1'b1, 50, 1'b1);
        run(j, 0, 0);
        chkk("t2_key", r_key, j.exp_key ^ 256'h1);
        chk1("t2_match", r_match, 1'b0);
        chki("t2_err", int'(r_err), 1);
        j = mk(1'b0, 30, 1'b1);
        run(j, 0, 2);
        chk1("t2b_match", r_match, 1'b0);
        chki("t2b_err", int'(r_err), 1);

        // 3: core never ready, then a normal job
        j = mk(1'b1, -1, 1'b0);
        run(j, 0, 0);
        chki("t3_latency", mon_res_rise - mon_first_start, 2000);
        chk1("t3_timeout", r_tmo, 1'b1);
        chkk("t3_key", r_key, '0);
        chki("t3_err", int'(r_err), 2);
        j = mk(1'b1, 20, 1'b0);
        run(j, 1, 0);
        chk1("t3b_match", r_match, 1'b1);
        chki("t3b_err", int'(r_err), 2);

        // timeout boundary: edge on the last counted cycle wins, one later times out
        j = mk(1'b1, TIMEOUT - 1, 1'b0);
        run(j, 0, 0);
        chk1("tb_edge_wins_timeout", r_tmo, 1'b0);
        chk1("tb_edge_wins_match", r_match, 1'b1);
        j = mk(1'b1, TIMEOUT, 1'b0);
        run(j, 0, 0);
        chk1("tb_late_timeout", r_tmo, 1'b1);
        chki("tb_late_err", int'(r_err), 3);

        // ready in the first start cycle ends the start pulse early
        j = mk(1'b1, 0, 1'b0);
        run(j, 0, 0);
        chki("te_start_cycles", mon_start, 1);
        chki("te_latency", mon_res_rise - mon_first_start, 1);

        // 4: held result blocks a pending job until the handshake
        ja = mk(1'b1, 10, 1'b0);
        jb = mk(1'b1, 15, 1'b0);
        @(posedge clk); #1;
        present(ja);
        wait_accept();
        @(posedge clk); #1;
        present(jb);
        collect(0, 10);
        chkk("t4_key_a", r_key, ja.exp_key);
        wait_accept();
        chki("t4_accept_after_hs", acc_cyc, hs_cyc + 1);
        collect(0, 0);
        chkk("t4_key_b", r_key, jb.exp_key);

        // 5: reset during WAIT, then a stray core ready edge
        j = mk(1'b1, 50, 1'b0);
        @(posedge clk); #1;
        present(j);
        wait_accept();
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        nres = n_results;
        force_rdy = 1;
        repeat (5) @(posedge clk);
        #1 force_rdy = 0;
        repeat (80) @(posedge clk);
        @(negedge clk);
        chki("t5_no_result", n_results, nres);
        chki("t5_err_cleared", int'(o_err_cnt), 0);

        // 6: 20 random vectors with random back-pressure
        nres = n_results;
        for (int i = 0; i < 20; i++) begin
            j = mk(1'b1, int'($urandom_range(0, 60)), 1'b0);
            run(j, 1, 0);
            chkk("t6_key", r_key, j.exp_key);
            chk1("t6_match", r_match, 1'b1);
        end
        chki("t6_count", n_results - nres, 20);
        chki("t6_err", int'(r_err), 0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
